// File: rtl/bin2bcd_display_feeder.sv
// bin2bcd_display_feeder
//   Iterative double-dabble converter: unsigned binary -> 8 packed BCD digits
//   for a MAX6951 running in hex-decode mode. One input bit per clock.
//   Values above 99_999_999 show as "EEEEEEEE". Outputs hold between
//   conversions so the display driver can keep scanning them.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous reset, active-high
//   in_bin    unsigned value to convert (BIN_WIDTH bits)
//   in_valid  in_bin valid this cycle
//   in_ready  idle, accepts in_bin on in_valid
//   busy      conversion in progress
//   bcd_data  packed BCD, [3:0] units .. [31:28] 10^7 digit
//   dps       decimal-point mask aligned with bcd_data digits
//   out_valid one-cycle pulse when bcd_data/dps update
module bin2bcd_display_feeder #(
    parameter int BIN_WIDTH = 27,
    parameter int DP_POS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIN_WIDTH-1:0] in_bin,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic [31:0]          bcd_data,
    output logic [7:0]           dps,
    output logic                 out_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [4:0]  CNT_INIT  = 5'(BIN_WIDTH - 1);
    localparam logic [7:0]  DPS_MASK  = (DP_POS < 8) ? (8'h01 << DP_POS) : 8'h00;
    localparam logic [26:0] MAX_DEC   = 27'd99_999_999;
    localparam logic [31:0] OVF_GLYPH = 32'hEEEE_EEEE;

    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
    logic [31:0]          scratch_q, scratch_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [31:0]          bcd_q, bcd_d;
    logic [7:0]           dps_q, dps_d;
    logic                 ovalid_q, ovalid_d;

    logic [31:0] scratch_adj;
    logic [26:0] in_ext;
    logic        accept;

    // Overflow check is always done at 27 bits, whatever BIN_WIDTH is.
    assign in_ext = 27'(in_bin);
    assign accept = in_valid && (state_q == S_IDLE);

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 8; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        dps_d     = dps_q;
        ovalid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_ext > MAX_DEC) begin
                        scratch_d = OVF_GLYPH;
                        state_d   = S_DONE;
                    end else begin
                        shreg_d   = in_bin;
                        scratch_d = 32'h0;
                        cnt_d     = CNT_INIT;
                        state_d   = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                if (cnt_q == 5'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_DONE: begin
                bcd_d    = scratch_q;
                dps_d    = DPS_MASK;
                ovalid_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            scratch_q <= 32'h0;
            cnt_q     <= 5'd0;
            bcd_q     <= 32'h0;
            dps_q     <= 8'h0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            dps_q     <= dps_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign bcd_data  = bcd_q;
    assign dps       = dps_q;
    assign out_valid = ovalid_q;

endmodule

// File: tb/tb_bin2bcd_display_feeder.sv
module tb_bin2bcd_display_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] in_bin;
    logic        in_valid;
    logic        in_ready, busy, out_valid;
    logic [31:0] bcd_data;
    logic [7:0]  dps;

    logic [7:0]  b_bin;
    logic        b_valid;
    logic        b_ready, b_busy, b_ovalid;
    logic [31:0] b_bcd;
    logic [7:0]  b_dps;

    always #5 clk = ~clk;

    bin2bcd_display_feeder #(.BIN_WIDTH(27), .DP_POS(8)) u_dut (
        .clk(clk), .reset(reset), .in_bin(in_bin), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .bcd_data(bcd_data), .dps(dps),
        .out_valid(out_valid)
    );

    bin2bcd_display_feeder #(.BIN_WIDTH(8), .DP_POS(2)) u_dut_b (
        .clk(clk), .reset(reset), .in_bin(b_bin), .in_valid(b_valid),
        .in_ready(b_ready), .busy(b_busy), .bcd_data(b_bcd), .dps(b_dps),
        .out_valid(b_ovalid)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bcd_of(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (v > 99_999_999) return 32'hEEEE_EEEE;
        r = 32'h0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] bcd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    logic [31:0] last_bcd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes expectations on accept, pops on out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bcd_data", bcd_data, e.bcd);
                chk("dps", 32'(dps), 32'h0);
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("ready_at_ov", 32'(in_ready), 32'd1);
            end
            last_bcd = bcd_data;
        end else if (bcd_data !== last_bcd) begin
            chk("bcd_hold", bcd_data, last_bcd);
            last_bcd = bcd_data;
        end
        if (reset) begin
            sb.delete();
            last_bcd = 32'h0;
        end else if (in_valid && in_ready) begin
            e.bcd = bcd_of(32'(in_bin));
            e.lat = (in_bin > 27'd99_999_999) ? 1 : 28;
            e.acc = cyc + 1;
            sb.push_back(e);
            acc_cnt++;
        end
    end

    task automatic send(input logic [26:0] v);
        int k = 0;
        @(posedge clk); #1;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b1;
        in_bin   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int target;
        int k;
        reset    = 1'b1;
        in_valid = 1'b1;      // reset wins over a simultaneous in_valid
        in_bin   = 27'd5;
        b_valid  = 1'b0;
        b_bin    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_bcd", bcd_data, 32'h0);
        chk("rst_dps", 32'(dps), 32'h0);
        chk("rst_no_accept", 32'(acc_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        send(27'd0);          wait_drain("drain_0");
        send(27'd12_345_678); wait_drain("drain_12345678");
        send(27'd99_999_999); wait_drain("drain_max");
        send(27'd9);          wait_drain("drain_9");
        send(27'd100_000_000); wait_drain("drain_ovf");
        send(27'h7FF_FFFF);   wait_drain("drain_ovf_max");

        // Back-to-back: in_valid held, fresh value every cycle.
        target = acc_cnt + 8;
        k = 0;
        in_valid = 1'b1;
        while (acc_cnt < target && k < 1000) begin
            in_bin = 27'($urandom_range(0, (1 << 27) - 1));
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt), 32'(target));
        wait_drain("drain_b2b");

        // Reset in the middle of a conversion.
        send(27'd55_555_555);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_bcd", bcd_data, 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        send(27'd42);         wait_drain("drain_42");

        // Narrow build with decimal point on digit 2.
        @(posedge clk); #1;
        b_valid = 1'b1;
        b_bin   = 8'd255;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_ovalid) begin
                lat = i;
                break;
            end
        end
        chk("b_latency", 32'(lat), 32'd9);
        chk("b_bcd", b_bcd, 32'h0000_0255);
        chk("b_dps", 32'(b_dps), 32'h04);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
